tagged_flow_tx: RTL and testbench

Transmitter end of the multi-flow tagged write interface consumed by the accelerator input FIFOs (for example the in_pel port of top_ms). It takes FLUX independent per-flow byte streams and holds one token per flow. It round-robin arbitrates among the flows whose destination FIFO is not full, and emits one tagged write per cycle as din = {flow_tag, data}. Per-flow token counters flag completion of a configured frame length, replacing the hand-written feed loop used in benches and the host-side bridge.

---
 rtl/tagged_flow_tx_pkg.sv | 24 ++
 rtl/tagged_flow_tx_if.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/tagged_flow_tx.sv | 116 +++++++++++
 tb/tb_tagged_flow_tx.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tagged_flow_tx_pkg.sv
// Shared definitions for the tagged multi-flow write path (tx mux and rx demux).
package mdf_flow_pkg;
   localparam int FLUX_DEF  = 4;
   localparam int TAG_W_DEF = $clog2(FLUX_DEF);

   typedef logic [TAG_W_DEF-1:0] flow_tag_t;

   // First set bit of req after ptr, wrapping modulo n (power of 2); returns ptr when req is empty.
   function automatic logic [31:0] flow_rr_next(input logic [31:0] ptr,
                                                input logic [31:0] req,
                                                input logic [31:0] n);
      logic [31:0] idx;
      logic        found;
      flow_rr_next = ptr;
      found        = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         idx = (ptr + 32'(i)) & (n - 32'd1);
         if (!found && (32'(i) <= n) && (((req >> idx) & 32'd1) != 32'd0)) begin
            flow_rr_next = idx;
            found        = 1'b1;
         end
      end
   endfunction
endpackage

// File: rtl/tagged_flow_tx_if.sv
// Per-flow source handshake plus tagged write port; master = transmitter side.
interface tagged_flow_tx_if
   import mdf_flow_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int FLUX   = FLUX_DEF,
   parameter int TAG_W  = $clog2(FLUX)
);
   logic [FLUX-1:0]         src_valid;
   logic [FLUX*DATA_W-1:0]  src_data;
   logic [FLUX-1:0]         src_ready;
   logic [TAG_W+DATA_W-1:0] wr_din;
   logic                    wr_write;
   logic [FLUX-1:0]         wr_full;

   modport master (input src_valid, src_data, wr_full,
                   output src_ready, wr_din, wr_write);
   modport slave  (output src_valid, src_data, wr_full,
                   input src_ready, wr_din, wr_write);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; pointer moves to the winner only when a grant is issued.
module rr_arbiter
   import mdf_flow_pkg::*;
#(
   parameter int FLUX  = FLUX_DEF,
   parameter int TAG_W = $clog2(FLUX)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FLUX-1:0]  req,
   output logic [FLUX-1:0]  grant,
   output logic [TAG_W-1:0] grant_idx
);
   logic [TAG_W-1:0] ptr;
   logic [31:0]      nxt;
   logic             unused_nxt_hi;

   always_comb begin
      nxt   = flow_rr_next(32'(ptr), 32'(req), 32'(FLUX));
      grant = '0;
      if (|req) grant[nxt[TAG_W-1:0]] = 1'b1;
   end

   assign grant_idx     = nxt[TAG_W-1:0];
   assign unused_nxt_hi = ^nxt[31:TAG_W];

   // Reset to the last index so the first grant after reset goes to flow 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        ptr <= TAG_W'(FLUX - 1);
      else if (|grant) ptr <= nxt[TAG_W-1:0];
   end
endmodule

// File: rtl/tagged_flow_tx.sv
// Multi-flow tagged write transmitter: one holding register per flow, RR mux, frame counters.
// Optional per-flow full-stall counters enabled by defining TAGGED_FLOW_TX_STATS_EN.
module tagged_flow_tx
   import mdf_flow_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int FLUX   = FLUX_DEF,
   parameter int TAG_W  = $clog2(FLUX),
   parameter int LEN_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   tagged_flow_tx_if.master   bus,
   input  logic               cfg_we,
   input  logic [TAG_W-1:0]   cfg_flow,
   input  logic [LEN_W-1:0]   cfg_len,
   output logic [FLUX-1:0]    frame_done,
   output logic               busy,
   output logic [FLUX*16-1:0] stall_cnt
);
   logic [FLUX-1:0]   hold_valid;
   logic [DATA_W-1:0] hold_data [FLUX];
   logic [FLUX-1:0]   elig;
   logic [FLUX-1:0]   grant;
   logic [TAG_W-1:0]  grant_idx;
   logic [FLUX-1:0]   cfg_hit;
   logic [LEN_W-1:0]  cnt    [FLUX];
   logic [LEN_W-1:0]  len_q  [FLUX];

   assign elig = hold_valid & ~bus.wr_full;

   rr_arbiter #(.FLUX(FLUX), .TAG_W(TAG_W)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (elig),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Granted flows may refill in the same cycle their token leaves.
   assign bus.src_ready = ~hold_valid | grant;
   assign bus.wr_write  = |grant;
   assign bus.wr_din    = bus.wr_write ? {grant_idx, hold_data[grant_idx]} : '0;
   assign busy          = |hold_valid;

   always_comb begin
      cfg_hit = '0;
      for (int f = 0; f < FLUX; f++) cfg_hit[f] = cfg_we && (cfg_flow == TAG_W'(f));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_valid <= '0;
         for (int f = 0; f < FLUX; f++) hold_data[f] <= '0;
      end else begin
         for (int f = 0; f < FLUX; f++) begin
            if (bus.src_valid[f] && bus.src_ready[f]) begin
               hold_valid[f] <= 1'b1;
               hold_data[f]  <= bus.src_data[f*DATA_W +: DATA_W];
            end else if (grant[f]) begin
               hold_valid[f] <= 1'b0;
            end
         end
      end
   end

   // A config write wins over a same-cycle grant: that write is not counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_done <= '0;
         for (int f = 0; f < FLUX; f++) begin
            cnt[f]   <= '0;
            len_q[f] <= '0;
         end
      end else begin
         frame_done <= '0;
         for (int f = 0; f < FLUX; f++) begin
            if (cfg_hit[f]) begin
               len_q[f] <= cfg_len;
               cnt[f]   <= '0;
            end else if (grant[f]) begin
               if ((len_q[f] != '0) && ((cnt[f] + LEN_W'(1)) == len_q[f])) begin
                  cnt[f]        <= '0;
                  frame_done[f] <= 1'b1;
               end else begin
                  cnt[f] <= cnt[f] + LEN_W'(1);
               end
            end
         end
      end
   end

`ifdef TAGGED_FLOW_TX_STATS_EN
   logic [15:0] stall_q [FLUX];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int f = 0; f < FLUX; f++) stall_q[f] <= '0;
      end else begin
         for (int f = 0; f < FLUX; f++) begin
            if (cfg_hit[f])
               stall_q[f] <= '0;
            else if (hold_valid[f] && bus.wr_full[f] && (stall_q[f] != 16'hFFFF))
               stall_q[f] <= stall_q[f] + 16'd1;
         end
      end
   end

   always_comb begin
      stall_cnt = '0;
      for (int f = 0; f < FLUX; f++) stall_cnt[f*16 +: 16] = stall_q[f];
   end
`else
   assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_tagged_flow_tx.sv
// Scoreboard bench for tagged_flow_tx: per-flow expected-payload queues filled on source acceptance.
module tb_tagged_flow_tx;
   import mdf_flow_pkg::*;

   localparam int NF    = 4;
   localparam int DW    = 8;
   localparam int FRAME = 529;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_flow = '0;
   logic [15:0] cfg_len = '0;
   logic [3:0]  frame_done;
   logic        busy;
   logic [63:0] stall_cnt;

   tagged_flow_tx_if #(.DATA_W(DW), .FLUX(NF)) bus ();

   tagged_flow_tx #(.DATA_W(DW), .FLUX(NF), .LEN_W(16)) dut (
      .clk        (clk),
      .rst        (rst_n),
      .bus        (bus),
      .cfg_we     (cfg_we),
      .cfg_flow   (cfg_flow),
      .cfg_len    (cfg_len),
      .frame_done (frame_done),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   logic [7:0]  exp_q [NF][$];
   int          next_idx [NF];
   logic [3:0]  en;
   int          limit;
   bit          use_file;
   logic [7:0]  file_bytes [FRAME];
   logic        obs_write;
   logic [9:0]  obs_din;
   logic [3:0]  obs_ready;
   logic [3:0]  obs_done;
   int          n_checks;
   int          n_fail;

   function automatic logic [7:0] pay(input int f, input int k);
      if (use_file) return file_bytes[k % FRAME];
      return 8'(16 + f + 4 * k);
   endfunction

   // Bit 8 flags a pending entry so an empty queue never matches a real write.
   function automatic logic [8:0] sb_pop(input logic [1:0] t);
      if (exp_q[t].size() == 0) return 9'h000;
      return {1'b1, exp_q[t].pop_front()};
   endfunction

   task automatic drive_src();
      for (int f = 0; f < NF; f++) begin
         bus.src_valid[f]          = en[f] && (next_idx[f] < limit);
         bus.src_data[f*DW +: DW]  = pay(f, next_idx[f]);
      end
   endtask

   task automatic step();
      logic [3:0] acc;
      @(negedge clk);
      obs_write = bus.wr_write;
      obs_din   = bus.wr_din;
      obs_ready = bus.src_ready;
      obs_done  = frame_done;
      acc       = bus.src_valid & bus.src_ready;
      for (int f = 0; f < NF; f++)
         if (acc[f]) exp_q[f].push_back(bus.src_data[f*DW +: DW]);
      @(posedge clk);
      #1;
      for (int f = 0; f < NF; f++)
         if (acc[f]) next_idx[f]++;
      drive_src();
   endtask

   task automatic apply_reset();
      en = '0; bus.wr_full = '0; cfg_we = 1'b0; limit = 1 << 30; use_file = 1'b0;
      for (int f = 0; f < NF; f++) begin
         next_idx[f] = 0;
         exp_q[f].delete();
      end
      drive_src();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.wr_full = '0; limit = 1 << 30; use_file = 1'b0;
      for (int f = 0; f < NF; f++) next_idx[f] = 0;
      en = 4'hF;
      drive_src();
      rst_n = 1'b0;
      #3;
      n_checks++; if (bus.wr_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b expected 0", bus.wr_write); end
      n_checks++; if (bus.wr_din !== 10'h000) begin n_fail++; $display("FAIL rst_din: got %h expected 000", bus.wr_din); end
      n_checks++; if (bus.src_ready !== 4'hF) begin n_fail++; $display("FAIL rst_ready: got %b expected 1111", bus.src_ready); end
      n_checks++; if (frame_done !== 4'h0) begin n_fail++; $display("FAIL rst_done: got %b expected 0000", frame_done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_checks++; if (stall_cnt !== 64'd0) begin n_fail++; $display("FAIL rst_stall: got %h expected 0", stall_cnt); end
      apply_reset();
   endtask

   task automatic test_round_robin();
      logic [8:0] e;
      apply_reset();
      en = 4'hF;
      drive_src();
      step();
      n_checks++; if (obs_write !== 1'b0 || obs_din !== 10'h000) begin n_fail++; $display("FAIL rr_idle: got write=%b din=%h expected write=0 din=000", obs_write, obs_din); end
      for (int k = 0; k < 16; k++) begin
         step();
         n_checks++;
         if (obs_write !== 1'b1 || obs_din[9:8] !== 2'(k % 4)) begin
            n_fail++; $display("FAIL rr_order[%0d]: got write=%b tag=%0d expected write=1 tag=%0d", k, obs_write, obs_din[9:8], k % 4);
         end
         e = sb_pop(obs_din[9:8]);
         n_checks++; if ({1'b1, obs_din[7:0]} !== e) begin n_fail++; $display("FAIL rr_payload[%0d]: got %h expected %h", k, obs_din[7:0], e); end
      end
   endtask

   task automatic test_full_stall();
      logic [8:0] e;
      logic [1:0] seq [3];
      bit         seen1;
      seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd3;
      apply_reset();
      en = 4'hF;
      drive_src();
      step();
      bus.wr_full = 4'b0010;
      for (int k = 0; k < 20; k++) begin
         step();
         n_checks++;
         if (obs_write !== 1'b1 || obs_din[9:8] !== seq[k % 3]) begin
            n_fail++; $display("FAIL stall_order[%0d]: got write=%b tag=%0d expected write=1 tag=%0d", k, obs_write, obs_din[9:8], seq[k % 3]);
         end
         e = sb_pop(obs_din[9:8]);
         n_checks++; if ({1'b1, obs_din[7:0]} !== e) begin n_fail++; $display("FAIL stall_payload[%0d]: got %h expected %h", k, obs_din[7:0], e); end
         n_checks++; if (obs_ready[1] !== 1'b0) begin n_fail++; $display("FAIL stall_ready1[%0d]: got %b expected 0", k, obs_ready[1]); end
      end
`ifdef TAGGED_FLOW_TX_STATS_EN
      n_checks++; if (stall_cnt[31:16] !== 16'd20) begin n_fail++; $display("FAIL stall_cnt1: got %0d expected 20", stall_cnt[31:16]); end
`else
      n_checks++; if (stall_cnt !== 64'd0) begin n_fail++; $display("FAIL stall_cnt_off: got %h expected 0", stall_cnt); end
`endif
      bus.wr_full = 4'b0000;
      seen1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (obs_write === 1'b1 && obs_din[9:8] === 2'd1) seen1 = 1'b1;
         e = sb_pop(obs_din[9:8]);
         n_checks++; if ({1'b1, obs_din[7:0]} !== e) begin n_fail++; $display("FAIL release_payload[%0d]: got %h expected %h", k, obs_din[7:0], e); end
      end
      n_checks++; if (!seen1) begin n_fail++; $display("FAIL release_flow1: got no tag-1 write in 3 cycles, expected one"); end
   endtask

   task automatic test_frame_len();
      logic [8:0] e;
      logic [3:0] exp_done;
      int         wcount [NF];
      int         dcount [NF];
      apply_reset();
      for (int f = 0; f < NF; f++) begin
         cfg_we = 1'b1; cfg_flow = 2'(f); cfg_len = 16'(FRAME);
         step();
      end
      cfg_we = 1'b0;
      for (int f = 0; f < NF; f++) begin wcount[f] = 0; dcount[f] = 0; end
      use_file = 1'b1; limit = FRAME; en = 4'hF;
      drive_src();
      exp_done = '0;
      for (int c = 0; c < NF * FRAME + 40; c++) begin
         step();
         n_checks++; if (obs_done !== exp_done) begin n_fail++; $display("FAIL frame_done[cyc %0d]: got %b expected %b", c, obs_done, exp_done); end
         for (int f = 0; f < NF; f++) if (obs_done[f] === 1'b1) dcount[f]++;
         exp_done = '0;
         if (obs_write === 1'b1) begin
            e = sb_pop(obs_din[9:8]);
            n_checks++; if ({1'b1, obs_din[7:0]} !== e) begin n_fail++; $display("FAIL frame_payload[cyc %0d]: got %h expected %h", c, obs_din[7:0], e); end
            wcount[obs_din[9:8]]++;
            if (wcount[obs_din[9:8]] == FRAME) exp_done[obs_din[9:8]] = 1'b1;
         end
      end
      for (int f = 0; f < NF; f++) begin
         n_checks++; if (wcount[f] != FRAME) begin n_fail++; $display("FAIL frame_writes[%0d]: got %0d expected %0d", f, wcount[f], FRAME); end
         n_checks++; if (dcount[f] != 1) begin n_fail++; $display("FAIL frame_pulses[%0d]: got %0d expected 1", f, dcount[f]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] e;
      apply_reset();
      en = 4'b0100;
      drive_src();
      step();
      for (int k = 0; k < 10; k++) begin
         step();
         n_checks++; if (obs_write !== 1'b1 || obs_din[9:8] !== 2'd2) begin n_fail++; $display("FAIL b2b_tag[%0d]: got write=%b tag=%0d expected write=1 tag=2", k, obs_write, obs_din[9:8]); end
         e = sb_pop(2'd2);
         n_checks++; if ({1'b1, obs_din[7:0]} !== e) begin n_fail++; $display("FAIL b2b_payload[%0d]: got %h expected %h", k, obs_din[7:0], e); end
         n_checks++; if (obs_ready[2] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, obs_ready[2]); end
      end
   endtask

   task automatic test_async_reset();
      logic [8:0] e;
      apply_reset();
      for (int f = 0; f < NF; f++) begin
         cfg_we = 1'b1; cfg_flow = 2'(f); cfg_len = 16'd100;
         step();
      end
      cfg_we = 1'b0;
      en = 4'hF;
      drive_src();
      repeat (6) step();
      #2;
      n_checks++; if (bus.wr_write !== 1'b1) begin n_fail++; $display("FAIL arst_pre_write: got %b expected 1", bus.wr_write); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.wr_write !== 1'b0) begin n_fail++; $display("FAIL arst_write: got %b expected 0", bus.wr_write); end
      n_checks++; if (bus.wr_din !== 10'h000) begin n_fail++; $display("FAIL arst_din: got %h expected 000", bus.wr_din); end
      n_checks++; if (bus.src_ready !== 4'hF) begin n_fail++; $display("FAIL arst_ready: got %b expected 1111", bus.src_ready); end
      en = '0;
      drive_src();
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
      for (int f = 0; f < NF; f++) begin
         n_checks++; if (dut.cnt[f] !== 16'd0) begin n_fail++; $display("FAIL arst_cnt[%0d]: got %0d expected 0", f, dut.cnt[f]); end
      end
      @(posedge clk);
      #1;
      for (int f = 0; f < NF; f++) exp_q[f].delete();
      en = 4'hF;
      drive_src();
      step();
      step();
      n_checks++; if (obs_write !== 1'b1 || obs_din[9:8] !== 2'd0) begin n_fail++; $display("FAIL arst_first_grant: got write=%b tag=%0d expected write=1 tag=0", obs_write, obs_din[9:8]); end
      e = sb_pop(obs_din[9:8]);
      n_checks++; if ({1'b1, obs_din[7:0]} !== e) begin n_fail++; $display("FAIL arst_payload: got %h expected %h", obs_din[7:0], e); end
   endtask

   task automatic test_cfg_collision();
      logic [8:0] e;
      logic [3:0] exp_done;
      int         counted;
      apply_reset();
      cfg_we = 1'b1; cfg_flow = 2'd3; cfg_len = 16'd4;
      step();
      cfg_we = 1'b0;
      en = 4'b1000;
      drive_src();
      step();
      repeat (2) begin
         step();
         e = sb_pop(2'd3);
         n_checks++; if ({1'b1, obs_din[7:0]} !== e) begin n_fail++; $display("FAIL coll_pre_payload: got %h expected %h", obs_din[7:0], e); end
         n_checks++; if (obs_done !== 4'h0) begin n_fail++; $display("FAIL coll_pre_done: got %b expected 0000", obs_done); end
      end
      cfg_we = 1'b1; cfg_flow = 2'd3; cfg_len = 16'd4;
      step();
      cfg_we = 1'b0;
      n_checks++; if (obs_write !== 1'b1 || obs_din[9:8] !== 2'd3) begin n_fail++; $display("FAIL coll_grant: got write=%b tag=%0d expected write=1 tag=3", obs_write, obs_din[9:8]); end
      e = sb_pop(2'd3);
      n_checks++; if (dut.cnt[3] !== 16'd0) begin n_fail++; $display("FAIL coll_cnt: got %0d expected 0", dut.cnt[3]); end
      counted = 0;
      exp_done = '0;
      for (int k = 0; k < 10; k++) begin
         step();
         n_checks++; if (obs_done !== exp_done) begin n_fail++; $display("FAIL coll_done[%0d]: got %b expected %b", k, obs_done, exp_done); end
         exp_done = '0;
         if (obs_write === 1'b1 && obs_din[9:8] === 2'd3) begin
            e = sb_pop(2'd3);
            n_checks++; if ({1'b1, obs_din[7:0]} !== e) begin n_fail++; $display("FAIL coll_payload[%0d]: got %h expected %h", k, obs_din[7:0], e); end
            counted++;
            if (counted == 4) begin exp_done[3] = 1'b1; counted = 0; end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < FRAME; i++) file_bytes[i] = 8'($urandom_range(0, 255));
      test_reset();
      test_round_robin();
      test_full_stall();
      test_frame_len();
      test_back_to_back();
      test_async_reset();
      test_cfg_collision();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
